// File: rtl/scpu_prog_loader_8bit_if.sv
// scpu_prog_loader_8bit_if: byte-stream input and memory write bus of the program loader
//   s_data/s_valid/s_ready : valid/ready byte stream into the loader
//   m_addr/m_dataout/m_we  : memory write port driven by the loader
//   slave modport  : loader side
//   master modport : stream source / memory side
interface scpu_prog_loader_8bit_if #(
    parameter int ADDR_W = 9
) ();
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] m_addr;
    logic [7:0]        m_dataout;
    logic              m_we;

    modport slave (
        input  s_data, s_valid,
        output s_ready, m_addr, m_dataout, m_we
    );

    modport master (
        output s_data, s_valid,
        input  s_ready, m_addr, m_dataout, m_we
    );
endinterface

// File: rtl/scpu_prog_loader_8bit.sv
// scpu_prog_loader_8bit: boot loader that writes a framed, checksummed program image into memory and starts the CPU
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : stream input and memory write port (slave modport)
//   bus_sel    : 1 = loader owns memory mux, 0 = CPU owns it
//   cpu_enable : CPU enable level
//   cpu_start  : one-cycle CPU start pulse
//   load_done  : image loaded with good checksum, sticky until rst
//   load_err   : frame error (bad length, bad checksum or timeout)
// Frame: SYNC_BYTE, len_hi, len_lo, N data bytes, csum; N = {len_hi[0],len_lo}+1.
// Optional macro LOADER_TIMEOUT_EN adds an inter-byte timeout of TIMEOUT_CYC cycles.
module scpu_prog_loader_8bit #(
    parameter int                ADDR_W      = 9,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter logic [7:0]        SYNC_BYTE   = 8'hA5,
    parameter int                TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    scpu_prog_loader_8bit_if.slave bus,
    output logic                   bus_sel,
    output logic                   cpu_enable,
    output logic                   cpu_start,
    output logic                   load_done,
    output logic                   load_err
);
    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, CSUM, START, DONE, ERR
    } state_t;

    state_t            state_q, state_d;
    logic [8:0]        len_q, len_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [7:0]        m_dataout_q, m_dataout_d;
    logic              m_we_q, m_we_d;
    logic              bus_sel_q, bus_sel_d;
    logic              cpu_enable_q, cpu_enable_d;
    logic              cpu_start_q, cpu_start_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
    logic              ready;
    logic              acc;
    logic [7:0]        sum_next;

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMO_W-1:0] tmo_q, tmo_d;
`else
    logic unused_tmo;
    assign unused_tmo = TIMEOUT_CYC[0];
`endif

    assign ready    = !(state_q == START || state_q == DONE);
    assign acc      = bus.s_valid && ready;
    assign sum_next = sum_q + bus.s_data;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        m_addr_d     = m_addr_q;
        m_dataout_d  = m_dataout_q;
        m_we_d       = 1'b0;
        bus_sel_d    = bus_sel_q;
        cpu_enable_d = cpu_enable_q;
        cpu_start_d  = 1'b0;
        load_done_d  = load_done_q;
        load_err_d   = load_err_q;
        case (state_q)
            IDLE: begin
                if (acc && bus.s_data == SYNC_BYTE)
                    state_d = LEN_HI;
            end
            LEN_HI: begin
                if (acc) begin
                    if (|bus.s_data[7:1]) begin
                        state_d    = ERR;
                        load_err_d = 1'b1;
                    end else begin
                        len_d   = {bus.s_data[0], 8'd0};
                        state_d = LEN_LO;
                    end
                end
            end
            LEN_LO: begin
                if (acc) begin
                    len_d   = {len_q[8], bus.s_data};
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (acc) begin
                    m_we_d      = 1'b1;
                    m_addr_d    = BASE_ADDR + ADDR_W'(cnt_q);
                    m_dataout_d = bus.s_data;
                    sum_d       = sum_next;
                    cnt_d       = cnt_q + 9'd1;
                    // len_q holds N-1, so equality marks the Nth byte
                    if (cnt_q == len_q)
                        state_d = CSUM;
                end
            end
            CSUM: begin
                if (acc) begin
                    if (sum_next == 8'd0) begin
                        state_d      = START;
                        bus_sel_d    = 1'b0;
                        cpu_enable_d = 1'b1;
                        cpu_start_d  = 1'b1;
                        load_done_d  = 1'b1;
                    end else begin
                        state_d    = ERR;
                        load_err_d = 1'b1;
                    end
                end
            end
            START: state_d = DONE;
            DONE:  state_d = DONE;
            ERR: begin
                if (acc && bus.s_data == SYNC_BYTE) begin
                    load_err_d = 1'b0;
                    state_d    = LEN_HI;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef LOADER_TIMEOUT_EN
        tmo_d = '0;
        if (state_q == LEN_HI || state_q == LEN_LO || state_q == DATA || state_q == CSUM) begin
            // leave on the edge where the count would reach TIMEOUT_CYC-1
            if (acc)
                tmo_d = '0;
            else if (tmo_q == TMO_W'(TIMEOUT_CYC - 2)) begin
                state_d    = ERR;
                load_err_d = 1'b1;
            end else
                tmo_d = tmo_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            sum_q        <= '0;
            m_addr_q     <= '0;
            m_dataout_q  <= '0;
            m_we_q       <= 1'b0;
            bus_sel_q    <= 1'b1;
            cpu_enable_q <= 1'b0;
            cpu_start_q  <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            m_addr_q     <= m_addr_d;
            m_dataout_q  <= m_dataout_d;
            m_we_q       <= m_we_d;
            bus_sel_q    <= bus_sel_d;
            cpu_enable_q <= cpu_enable_d;
            cpu_start_q  <= cpu_start_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
`ifdef LOADER_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign bus.s_ready   = ready;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_dataout = m_dataout_q;
    assign bus.m_we      = m_we_q;
    assign bus_sel       = bus_sel_q;
    assign cpu_enable    = cpu_enable_q;
    assign cpu_start     = cpu_start_q;
    assign load_done     = load_done_q;
    assign load_err      = load_err_q;
endmodule
